processor_datapath: RTL and testbench
=====================================

# processor_datapath

Datapath for the 16-bit accumulator-less load/store processor, sitting directly downstream of the control state machine. It holds the 16×16 register file, the 8-function ALU, the 256×16 data memory and the write-back mux. It executes whatever control word the state machine drives each cycle: Store, Load (two-cycle), Add, Sub or idle.

## Interface
Parameters:
- DATA_W, 16, datapath word width
- RF_DEPTH, 16, register file entries (address width 4)
- DM_DEPTH, 256, data memory words (address width 8)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears register file and memory read register
- D_addr  input  8  data memory address
- D_wr  input  1  data memory write enable
- RF_s  input  1  write-back select: 0 = ALU result, 1 = memory read data
- RF_W_addr  input  4  register file write address
- RF_W_en  input  1  register file write enable
- RF_Ra_addr  input  4  read port A address
- RF_Rb_addr  input  4  read port B address
- ALU_s0  input  3  ALU function select
- Ra_data  output  16  register file port A read value (debug/observe)
- Rb_data  output  16  register file port B read value
- ALU_out  output  16  ALU result
- ALU_zero  output  1  high when ALU_out == 0
- D_rd_data  output  16  registered data memory read value

## Operation
- Register file: 16 entries, two combinational read ports, one synchronous write port. Entry 0 is an ordinary writable register.
- Write-back value W_data = RF_s ? D_rd_data : ALU_out. It is written to RF_W_addr on the rising edge when RF_W_en = 1.
- Data memory: synchronous write and synchronous read.
  - On every edge, D_rd_data <= mem[D_addr].
  - When D_wr = 1, mem[D_addr] <= Ra_data.
  - Store data always comes from port A.
- ALU functions, all modulo 2^16 with carry/borrow discarded:
  - 0 pass A
  - 1 A+B
  - 2 A−B
  - 3 A|B
  - 4 A&B
  - 5 A^B
  - 6 ~A
  - 7 zero
  - A = Ra_data, B = Rb_data.
- Load (two cycles):
  - Cycle 1 presents D_addr. D_rd_data becomes valid after that edge.
  - Cycle 2 presents the same D_addr with RF_s = 1 and RF_W_en = 1, writing the correct data.
  - The cycle-1 write lands stale D_rd_data in the destination and is overwritten in cycle 2. This behaviour is required, not an error.
- Idle (all enables 0): no architectural state changes. D_rd_data still tracks mem[D_addr].

## Timing
- Reset values:
  - all 16 registers = 0
  - D_rd_data = 0
  - Ra_data = Rb_data = 0
  - ALU_out follows ALU_s0 on zero operands
  - ALU_zero = 1 for every function except 6 (~A = 0xFFFF gives ALU_zero = 0)
  - Memory contents are not reset.
- Reset is asserted asynchronously and deasserted synchronously by the environment. Reset mid-Load abandons the load; the destination register reads 0.
- Register read latency is 0: combinational from address to output. Register write is visible on read ports the cycle after the edge.
- Same-cycle write and read of the same register: the read port shows the old value (no bypass).
- Same-cycle D_wr and read at the same D_addr: D_rd_data gets the old contents (read-before-write). The new value is readable one cycle later.
- D_wr and RF_W_en both high: both happen independently on the same edge.
- Address wrap: none needed. Addresses are full-width and every value is legal.

## Structure
- Shared package proc_pkg holds:
  - alu_op_t enum (3-bit): ALU_PASS, ALU_ADD, ALU_SUB, ALU_OR, ALU_AND, ALU_XOR, ALU_NOT, ALU_ZERO
  - DATA_W, RF_AW = 4 and DM_AW = 8 constants, shared with the control state machine
- Sub-module register_file: 16×16, two read ports, one write port, asynchronous reset.
- ALU and write-back mux stay inline. Data memory is an inferred array with a registered read.

## Test plan
- Reset test: assert reset mid-run, then read all 16 registers via Ra/Rb. Required: all read 0, D_rd_data = 0, ALU_zero = 1 with ALU_s0 = 1.
- Store/Load round-trip:
  - Preload R15 = 0x1234 via the backdoor or an Add from zeroed registers after loading a memory-seeded value.
  - Store R15 → mem[41].
  - Load mem[41] → R7 over two cycles.
  - Required: R7 = 0x1234 after cycle 2. R7 holds the stale value after cycle 1.
- Add/Sub: R1 = 5, R2 = 7. Add R1,R2 → R3 gives 12. Sub R1,R2 → R3 gives 0xFFFE with ALU_zero = 0. Sub R1,R1 gives 0 with ALU_zero = 1.
- Overflow: R1 = 0xFFFF, R2 = 1. Add gives 0x0000 with ALU_zero = 1.
- Collisions:
  - Write R4 = 0xAAAA while reading R4 in the same cycle: port shows the old value, then 0xAAAA next cycle.
  - D_wr to mem[10] with D_addr = 10: D_rd_data shows the old word, then the new word next cycle.
- Idle: 20 cycles with all enables 0. Required: register file and memory unchanged, verified by full readback.

Source files
------------

// File: rtl/proc_pkg.sv
// Purpose: shared types and widths for the 16-bit load/store processor.
// Latency: n/a (declarations only).
// Backpressure: n/a; the control state machine imports the same constants.
package proc_pkg;

  localparam int DATA_W = 16;
  localparam int RF_AW  = 4;
  localparam int DM_AW  = 8;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_AND  = 3'd4,
    ALU_XOR  = 3'd5,
    ALU_NOT  = 3'd6,
    ALU_ZERO = 3'd7
  } alu_op_t;

endpackage

// File: rtl/register_file.sv
// Purpose: 2-read / 1-write register file, cleared by reset.
// Latency: reads are combinational; a write is visible the cycle after its edge.
// Backpressure: none; a write is accepted every cycle w_en is high.
//
// Ports: clk, reset (async active-high), w_en/w_addr/w_data (write port),
//        ra_addr/ra_data and rb_addr/rb_data (read ports, no write bypass).
module register_file
  import proc_pkg::*;
#(
  parameter int DATA_W = proc_pkg::DATA_W,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_en,
  input  logic [AW-1:0]     w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [AW-1:0]     ra_addr,
  input  logic [AW-1:0]     rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data
);

  logic [DATA_W-1:0] regs [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (w_en) begin
      regs[w_addr] <= w_data;
    end
  end

  // Reads see the pre-edge contents: a same-cycle write is not forwarded.
  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];

endmodule

// File: rtl/processor_datapath.sv
// Purpose: processor datapath - register file, 8-function ALU, data memory, write-back mux.
// Latency: ALU is combinational; register write and memory read/write land on the next edge.
// Backpressure: none; executes whatever control word is presented every cycle.
//
// Ports: clk, reset (async active-high); D_addr/D_wr (data memory control);
//        RF_s (write-back select), RF_W_addr/RF_W_en (register write);
//        RF_Ra_addr/RF_Rb_addr (read ports); ALU_s0 (ALU function);
//        outputs Ra_data, Rb_data, ALU_out, ALU_zero, D_rd_data.
module processor_datapath
  import proc_pkg::*;
#(
  parameter int DATA_W   = proc_pkg::DATA_W,
  parameter int RF_DEPTH = 16,
  parameter int DM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DM_AW-1:0]  D_addr,
  input  logic              D_wr,
  input  logic              RF_s,
  input  logic [RF_AW-1:0]  RF_W_addr,
  input  logic              RF_W_en,
  input  logic [RF_AW-1:0]  RF_Ra_addr,
  input  logic [RF_AW-1:0]  RF_Rb_addr,
  input  logic [2:0]        ALU_s0,
  output logic [DATA_W-1:0] Ra_data,
  output logic [DATA_W-1:0] Rb_data,
  output logic [DATA_W-1:0] ALU_out,
  output logic              ALU_zero,
  output logic [DATA_W-1:0] D_rd_data
);

  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] mem [DM_DEPTH];
  alu_op_t           alu_op;

  register_file #(
    .DATA_W (DATA_W),
    .DEPTH  (RF_DEPTH),
    .AW     (RF_AW)
  ) u_rf (
    .clk     (clk),
    .reset   (reset),
    .w_en    (RF_W_en),
    .w_addr  (RF_W_addr),
    .w_data  (w_data),
    .ra_addr (RF_Ra_addr),
    .rb_addr (RF_Rb_addr),
    .ra_data (Ra_data),
    .rb_data (Rb_data)
  );

  // ALU: all results wrap modulo 2^DATA_W, carry/borrow dropped.
  assign alu_op = alu_op_t'(ALU_s0);

  always_comb begin
    ALU_out = '0;
    case (alu_op)
      ALU_PASS: ALU_out = Ra_data;
      ALU_ADD:  ALU_out = Ra_data + Rb_data;
      ALU_SUB:  ALU_out = Ra_data - Rb_data;
      ALU_OR:   ALU_out = Ra_data | Rb_data;
      ALU_AND:  ALU_out = Ra_data & Rb_data;
      ALU_XOR:  ALU_out = Ra_data ^ Rb_data;
      ALU_NOT:  ALU_out = ~Ra_data;
      ALU_ZERO: ALU_out = '0;
      default:  ALU_out = '0;
    endcase
  end

  assign ALU_zero = (ALU_out == '0);

  // Write-back mux. During the first Load cycle this deliberately picks up
  // the previous read; the second cycle overwrites it with the right word.
  assign w_data = RF_s ? D_rd_data : ALU_out;

  // Data memory array: no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (D_wr) begin
      mem[D_addr] <= Ra_data;
    end
  end

  // Registered read samples the pre-edge contents, so a same-address
  // write returns the old word first (read-before-write).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      D_rd_data <= '0;
    end else begin
      D_rd_data <= mem[D_addr];
    end
  end

endmodule

// File: tb/tb_processor_datapath.sv
// Purpose: self-checking bench for processor_datapath against a behavioural model.
// Latency: model updates once per rising edge, outputs checked mid-cycle.
// Backpressure: n/a.
module tb_processor_datapath;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  D_addr = '0;
  logic        D_wr = 1'b0;
  logic        RF_s = 1'b0;
  logic [3:0]  RF_W_addr = '0;
  logic        RF_W_en = 1'b0;
  logic [3:0]  RF_Ra_addr = '0;
  logic [3:0]  RF_Rb_addr = '0;
  logic [2:0]  ALU_s0 = '0;
  logic [15:0] Ra_data, Rb_data, ALU_out, D_rd_data;
  logic        ALU_zero;

  int n_checks = 0;
  int n_fail = 0;

  // Architectural model
  logic [15:0] m_rf [16];
  logic [15:0] m_mem [256];
  logic [15:0] m_rd;

  processor_datapath dut (
    .clk        (clk),
    .reset      (reset),
    .D_addr     (D_addr),
    .D_wr       (D_wr),
    .RF_s       (RF_s),
    .RF_W_addr  (RF_W_addr),
    .RF_W_en    (RF_W_en),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .ALU_s0     (ALU_s0),
    .Ra_data    (Ra_data),
    .Rb_data    (Rb_data),
    .ALU_out    (ALU_out),
    .ALU_zero   (ALU_zero),
    .D_rd_data  (D_rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] ref_alu(input int op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      0: return a;
      1: return 16'((32'(a) + 32'(b)) % 65536);
      2: return 16'((32'(a) + 65536 - 32'(b)) % 65536);
      3: return a | b;
      4: return a & b;
      5: return a ^ b;
      6: return 16'(65535 - 32'(a));
      default: return 16'h0000;
    endcase
  endfunction

  // Present a control word shortly after an edge.
  task automatic drive(input int addr, input int wr, input int rs, input int wa, input int we,
                       input int ra, input int rb, input int op);
    logic [31:0] v;
    v = addr; D_addr = v[7:0];
    v = wr;   D_wr = v[0];
    v = rs;   RF_s = v[0];
    v = wa;   RF_W_addr = v[3:0];
    v = we;   RF_W_en = v[0];
    v = ra;   RF_Ra_addr = v[3:0];
    v = rb;   RF_Rb_addr = v[3:0];
    v = op;   ALU_s0 = v[2:0];
    #2;
  endtask

  // Advance one edge and apply the same control word to the model.
  task automatic tick();
    logic [15:0] a, b, w, nrd;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 16; i++) m_rf[i] = 16'h0;
      m_rd = 16'h0;
    end else begin
      a = m_rf[RF_Ra_addr];
      b = m_rf[RF_Rb_addr];
      w = RF_s ? m_rd : ref_alu(int'(ALU_s0), a, b);
      nrd = m_mem[D_addr];
      if (D_wr) m_mem[D_addr] = a;
      if (RF_W_en) m_rf[RF_W_addr] = w;
      m_rd = nrd;
    end
    #1;
  endtask

  // Synthesize a constant from zeroed operands: R12 = 1, then shift-and-add.
  task automatic build(input int rd, input logic [15:0] val);
    drive(0, 0, 0, 13, 1, 0, 0, 7); tick();
    drive(0, 0, 0, 12, 1, 13, 0, 6); tick();
    drive(0, 0, 0, 12, 1, 13, 12, 2); tick();
    drive(0, 0, 0, rd, 1, 0, 0, 7); tick();
    for (int b = 15; b >= 0; b--) begin
      drive(0, 0, 0, rd, 1, rd, rd, 1); tick();
      if (val[b]) begin
        drive(0, 0, 0, rd, 1, rd, 12, 1); tick();
      end
    end
  endtask

  task automatic test_reset(input bit with_load);
    if (with_load) begin
      drive(41, 0, 1, 7, 1, 15, 15, 0); tick();
      drive(41, 0, 1, 7, 1, 7, 7, 0);
    end else begin
      drive(0, 0, 0, 0, 0, 0, 0, 6);
    end
    reset = 1'b1;
    #1;
    if (with_load) begin
      n_checks++;
      if (Ra_data !== 16'h0) begin n_fail++; $display("FAIL reset_abandon_load: R7 got %h want 0000", Ra_data); end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 6);
    n_checks++;
    if (ALU_out !== 16'hFFFF || ALU_zero !== 1'b0) begin
      n_fail++; $display("FAIL reset_not_op: ALU_out=%h zero=%b want ffff 0", ALU_out, ALU_zero);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 0, 0, i, 15 - i, 1);
      n_checks++;
      if (Ra_data !== 16'h0 || Rb_data !== 16'h0) begin
        n_fail++; $display("FAIL reset_regs[%0d]: Ra=%h Rb=%h want 0000 0000", i, Ra_data, Rb_data);
      end
      if (i == 0) begin
        n_checks++;
        if (D_rd_data !== 16'h0 || ALU_zero !== 1'b1) begin
          n_fail++; $display("FAIL reset_rd_zero: D_rd_data=%h ALU_zero=%b want 0000 1", D_rd_data, ALU_zero);
        end
      end
      tick();
    end
  endtask

  task automatic init_mem();
    for (int i = 0; i < 256; i++) begin
      drive(i, 1, 0, 0, 0, 0, 0, 0); tick();
    end
  endtask

  task automatic test_store_load();
    build(15, 16'h1234);
    drive(41, 1, 0, 0, 0, 15, 0, 0); tick();
    drive(41, 0, 1, 7, 1, 15, 15, 0); tick();
    drive(41, 0, 1, 7, 1, 7, 7, 0);
    n_checks++;
    if (Ra_data !== m_rf[7]) begin n_fail++; $display("FAIL load_stale: R7 got %h want %h", Ra_data, m_rf[7]); end
    n_checks++;
    if (D_rd_data !== 16'h1234) begin n_fail++; $display("FAIL load_rd_data: got %h want 1234", D_rd_data); end
    tick();
    drive(0, 0, 0, 0, 0, 7, 0, 0);
    n_checks++;
    if (Ra_data !== 16'h1234) begin n_fail++; $display("FAIL load_result: R7 got %h want 1234", Ra_data); end
    tick();
  endtask

  task automatic test_add_sub();
    build(1, 16'd5);
    build(2, 16'd7);
    drive(0, 0, 0, 3, 1, 1, 2, 1);
    n_checks++;
    if (ALU_out !== 16'd12 || ALU_zero !== 1'b0) begin n_fail++; $display("FAIL add: got %h/%b want 000c/0", ALU_out, ALU_zero); end
    tick();
    drive(0, 0, 0, 3, 1, 1, 2, 2);
    n_checks++;
    if (ALU_out !== 16'hFFFE || ALU_zero !== 1'b0) begin n_fail++; $display("FAIL sub_neg: got %h/%b want fffe/0", ALU_out, ALU_zero); end
    tick();
    drive(0, 0, 0, 0, 0, 1, 3, 2);
    n_checks++;
    if (Rb_data !== 16'hFFFE) begin n_fail++; $display("FAIL sub_wb: R3 got %h want fffe", Rb_data); end
    tick();
    drive(0, 0, 0, 0, 0, 1, 1, 2);
    n_checks++;
    if (ALU_out !== 16'h0 || ALU_zero !== 1'b1) begin n_fail++; $display("FAIL sub_self: got %h/%b want 0000/1", ALU_out, ALU_zero); end
    tick();
  endtask

  task automatic test_overflow();
    build(1, 16'hFFFF);
    build(2, 16'h0001);
    drive(0, 0, 0, 3, 1, 1, 2, 1);
    n_checks++;
    if (ALU_out !== 16'h0 || ALU_zero !== 1'b1) begin n_fail++; $display("FAIL overflow: got %h/%b want 0000/1", ALU_out, ALU_zero); end
    tick();
  endtask

  task automatic test_collisions();
    logic [15:0] old;
    build(4, 16'h5555);
    drive(0, 0, 0, 4, 1, 4, 4, 6);
    n_checks++;
    if (Rb_data !== 16'h5555 || ALU_out !== 16'hAAAA) begin
      n_fail++; $display("FAIL rf_collide_old: Rb=%h ALU=%h want 5555 aaaa", Rb_data, ALU_out);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 4, 0);
    n_checks++;
    if (Rb_data !== 16'hAAAA) begin n_fail++; $display("FAIL rf_collide_new: got %h want aaaa", Rb_data); end
    tick();
    build(5, 16'hBEEF);
    drive(10, 0, 0, 0, 0, 5, 0, 0); tick();
    old = m_mem[10];
    drive(10, 1, 0, 0, 0, 5, 0, 0);
    n_checks++;
    if (D_rd_data !== old) begin n_fail++; $display("FAIL mem_pre_write: got %h want %h", D_rd_data, old); end
    tick();
    drive(10, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (D_rd_data !== old) begin n_fail++; $display("FAIL mem_rbw_old: got %h want %h", D_rd_data, old); end
    tick();
    drive(10, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (D_rd_data !== 16'hBEEF) begin n_fail++; $display("FAIL mem_rbw_new: got %h want beef", D_rd_data); end
    tick();
  endtask

  task automatic test_random();
    logic [15:0] exp_alu;
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15),
            ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 1), $urandom_range(0, 15),
            $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
      exp_alu = ref_alu(int'(ALU_s0), m_rf[RF_Ra_addr], m_rf[RF_Rb_addr]);
      n_checks++;
      if (Ra_data !== m_rf[RF_Ra_addr] || Rb_data !== m_rf[RF_Rb_addr]) begin
        n_fail++; $display("FAIL rand_read[%0d]: Ra=%h Rb=%h want %h %h", n, Ra_data, Rb_data, m_rf[RF_Ra_addr], m_rf[RF_Rb_addr]);
      end
      n_checks++;
      if (ALU_out !== exp_alu || ALU_zero !== (exp_alu == 16'h0)) begin
        n_fail++; $display("FAIL rand_alu[%0d]: op=%0d got %h/%b want %h", n, ALU_s0, ALU_out, ALU_zero, exp_alu);
      end
      n_checks++;
      if (D_rd_data !== m_rd) begin n_fail++; $display("FAIL rand_rd[%0d]: got %h want %h", n, D_rd_data, m_rd); end
      tick();
    end
  endtask

  task automatic test_idle();
    logic [15:0] snap_rf [16];
    logic [15:0] snap_mem [256];
    for (int i = 0; i < 16; i++) snap_rf[i] = m_rf[i];
    for (int i = 0; i < 256; i++) snap_mem[i] = m_mem[i];
    for (int n = 0; n < 20; n++) begin
      drive($urandom_range(0, 255), 0, $urandom_range(0, 1), $urandom_range(0, 15), 0,
            $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 0, 0, i, i, 0);
      n_checks++;
      if (Ra_data !== snap_rf[i]) begin n_fail++; $display("FAIL idle_rf[%0d]: got %h want %h", i, Ra_data, snap_rf[i]); end
      tick();
    end
    for (int i = 0; i <= 256; i++) begin
      drive(i % 256, 0, 0, 0, 0, 0, 0, 0);
      if (i > 0) begin
        n_checks++;
        if (D_rd_data !== snap_mem[i - 1]) begin
          n_fail++; $display("FAIL idle_mem[%0d]: got %h want %h", i - 1, D_rd_data, snap_mem[i - 1]);
        end
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_rf[i] = 16'h0;
    for (int i = 0; i < 256; i++) m_mem[i] = 16'h0;
    m_rd = 16'h0;
    #1;
    test_reset(1'b0);
    init_mem();
    test_store_load();
    test_reset(1'b1);
    test_add_sub();
    test_overflow();
    test_collisions();
    test_random();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
